// File: rtl/btn_press_detect.sv
// N-channel button conditioner: 2-FF sync, debounce, power-up arming, short/long press pulses.
// Define BTN_STUCK_DETECT_EN to build the stuck-button detector driving o_stuck.
module btn_press_detect #(
    parameter int N_CH      = 2,
    parameter int ACTIVE_LOW = 1,
    parameter int DEB_CYC   = 32,
    parameter int ARM_CYC   = 65536,
    parameter int SHORT_CYC = 64,
    parameter int LONG_CYC  = 131072,
    parameter int STUCK_CYC = 524288
) (
    input  logic            i_clk_32k,
    input  logic            i_rst_n,
    input  logic [N_CH-1:0] i_btn,
    output logic [N_CH-1:0] o_btn_held,
    output logic [N_CH-1:0] o_short_pulse,
    output logic [N_CH-1:0] o_long_pulse,
    output logic [N_CH-1:0] o_stuck
);

    localparam int MAX_A   = (DEB_CYC > ARM_CYC) ? DEB_CYC : ARM_CYC;
    localparam int MAX_B   = (LONG_CYC > STUCK_CYC) ? LONG_CYC : STUCK_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(MAX_CYC + 1);

    // Pin level that means "not pressed"; also the synchroniser reset value.
    localparam logic REL_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    localparam logic [CW-1:0] DEB_TERM   = CW'(DEB_CYC - 1);
    localparam logic [CW-1:0] ARM_TERM   = CW'(ARM_CYC - 1);
    localparam logic [CW-1:0] SHORT_MIN  = CW'(SHORT_CYC);
    localparam logic [CW-1:0] LONG_TERM  = CW'(LONG_CYC - 1);
`ifdef BTN_STUCK_DETECT_EN
    localparam logic [CW-1:0] STUCK_TERM = CW'(STUCK_CYC - 1);
`endif

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_IDLE     = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_LONG     = 2'd3
    } state_e;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic          sync1_q;
        logic          sync2_q;
        logic          press_s;
        logic          deb_q;
        logic          deb_d;
        logic [CW-1:0] deb_cnt_q;
        logic [CW-1:0] deb_cnt_d;
        state_e        state_q;
        logic [CW-1:0] arm_cnt_q;
        logic [CW-1:0] hold_cnt_q;
        logic          held_q;
        logic          short_q;
        logic          long_q;
`ifdef BTN_STUCK_DETECT_EN
        logic          stuck_q;
`endif

        // Two-flop synchroniser for the asynchronous pin.
        always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
            if (!i_rst_n) begin
                sync1_q <= REL_LVL;
                sync2_q <= REL_LVL;
            end else begin
                sync1_q <= i_btn[g];
                sync2_q <= sync1_q;
            end
        end

        assign press_s = sync2_q ^ REL_LVL;

        // Debounce: the level flips only after DEB_CYC consecutive disagreeing samples.
        always_comb begin
            deb_d     = deb_q;
            deb_cnt_d = '0;
            if (press_s != deb_q) begin
                if (deb_cnt_q == DEB_TERM) begin
                    deb_d     = ~deb_q;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + CW'(1);
                end
            end else begin
                deb_cnt_d = '0;
            end
        end

        // Debounce state registers.
        always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
            if (!i_rst_n) begin
                deb_q     <= 1'b0;
                deb_cnt_q <= '0;
            end else begin
                deb_q     <= deb_d;
                deb_cnt_q <= deb_cnt_d;
            end
        end

        // Arming / press-classification FSM with registered outputs.
        always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
            if (!i_rst_n) begin
                state_q    <= ST_DISARMED;
                arm_cnt_q  <= '0;
                hold_cnt_q <= '0;
                held_q     <= 1'b0;
                short_q    <= 1'b0;
                long_q     <= 1'b0;
`ifdef BTN_STUCK_DETECT_EN
                stuck_q    <= 1'b0;
`endif
            end else begin
                short_q <= 1'b0;
                long_q  <= 1'b0;
                case (state_q)
                    ST_DISARMED: begin
                        held_q <= 1'b0;
                        if (deb_q) begin
                            arm_cnt_q <= '0;
                        end else if (arm_cnt_q >= ARM_TERM) begin
                            state_q <= ST_IDLE;
`ifdef BTN_STUCK_DETECT_EN
                            stuck_q <= 1'b0;
`endif
                        end else begin
                            arm_cnt_q <= arm_cnt_q + CW'(1);
                        end
                    end
                    ST_IDLE: begin
                        if (deb_q) begin
                            state_q    <= ST_PRESSED;
                            hold_cnt_q <= '0;
                            held_q     <= 1'b1;
                        end else begin
                            held_q <= 1'b0;
                        end
                    end
                    ST_PRESSED: begin
                        // Release is checked first so it wins over the long threshold.
                        if (!deb_q) begin
                            state_q <= ST_IDLE;
                            held_q  <= 1'b0;
                            short_q <= (hold_cnt_q >= SHORT_MIN);
                        end else if (hold_cnt_q == LONG_TERM) begin
                            state_q    <= ST_LONG;
                            long_q     <= 1'b1;
                            hold_cnt_q <= hold_cnt_q + CW'(1);
                        end else begin
                            hold_cnt_q <= hold_cnt_q + CW'(1);
                        end
                    end
                    ST_LONG: begin
                        if (!deb_q) begin
                            state_q <= ST_IDLE;
                            held_q  <= 1'b0;
                        end else begin
`ifdef BTN_STUCK_DETECT_EN
                            if (hold_cnt_q >= STUCK_TERM) begin
                                state_q   <= ST_DISARMED;
                                stuck_q   <= 1'b1;
                                held_q    <= 1'b0;
                                arm_cnt_q <= '0;
                            end else begin
                                hold_cnt_q <= hold_cnt_q + CW'(1);
                            end
`else
                            held_q <= 1'b1;
`endif
                        end
                    end
                    default: begin
                        state_q <= ST_DISARMED;
                        held_q  <= 1'b0;
                    end
                endcase
            end
        end

        assign o_btn_held[g]    = held_q;
        assign o_short_pulse[g] = short_q;
        assign o_long_pulse[g]  = long_q;
`ifdef BTN_STUCK_DETECT_EN
        assign o_stuck[g]       = stuck_q;
`else
        assign o_stuck[g]       = 1'b0;
`endif
    end

endmodule
